// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: counts a loaded value down to zero once per clk,
// flags terminal count with a one-cycle tc pulse, optionally auto-reloads.
module down_counter_timer #(
  parameter int unsigned WIDTH       = 8,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload_reg, reload_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             count_is_zero;
  logic             count_is_one;
  logic             reload_is_zero;

  assign count_is_zero  = (count == '0);
  assign count_is_one   = (count == WIDTH'(1));
  assign reload_is_zero = (reload_reg == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_reg <= reload_nxt;
      tc         <= tc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload_reg;
    tc_nxt     = 1'b0;

    if (load) begin
      count_nxt  = load_val;
      reload_nxt = load_val;
      state_nxt  = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (count_is_zero) begin
              state_nxt = DONE;
              tc_nxt    = 1'b1;
            end else begin
              state_nxt = RUN;
            end
          end
        end

        RUN: begin
          if (!pause) begin
            if (count_is_zero) begin
              // Not reachable through normal entry; park safely without a pulse.
              state_nxt = DONE;
            end else if (count_is_one) begin
              tc_nxt = 1'b1;
              if (AUTO_RELOAD) begin
                count_nxt = reload_reg;
              end else begin
                count_nxt = '0;
                state_nxt = DONE;
              end
            end else begin
              count_nxt = count - WIDTH'(1);
            end
          end
        end

        DONE: begin
          if (start) begin
            count_nxt = reload_reg;
            if (reload_is_zero) begin
              tc_nxt = 1'b1;
            end else begin
              state_nxt = RUN;
            end
          end
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
